// File: rtl/sse_stream.sv
// sse_stream -- streaming sum-of-squared-error engine.
//
// Accepts signed operand pairs (A, B) over a valid/next handshake, with stop
// marking the last pair of a vector. Each vector produces sum((A-B)^2), the
// pair count and a sticky saturation flag, presented with a one-cycle ready
// pulse and held until the next result.
//
// Compile-time option: define SSE_MEAN_EN to report floor(sum / count)
// instead of the sum. A restoring divider (one quotient bit per cycle,
// ACC_W cycles) then runs in a DIV state between DRAIN and DONE.
//
// Ports:
//   clk      in  clock, rising edge
//   rst      in  asynchronous reset, active low
//   A, B     in  WIDTH-bit signed operands
//   valid    in  A, B and stop are valid this cycle
//   stop     in  current pair closes the vector (qualified by valid)
//   next     out block accepts a pair this cycle (transfer = valid && next)
//   ready    out one-cycle pulse: Y, count, overflow newly valid
//   Y        out ACC_W-bit result (sum, or mean with SSE_MEAN_EN)
//   count    out CNT_W-bit pair count of the reported vector
//   overflow out accumulator or counter saturated in the reported vector

module sse_stream #(
   parameter int WIDTH = 16,
   parameter int ACC_W = 48,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             valid,
   input  logic             stop,
   output logic             next,
   output logic             ready,
   output logic [ACC_W-1:0] Y,
   output logic [CNT_W-1:0] count,
   output logic             overflow
);

   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DIV   = 2'd2,   // reachable only with SSE_MEAN_EN
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t               state_r, state_nxt_s;
   logic [1:0]           drain_cnt_r;
   logic                 xfer_s, load_s, finish_s;
   logic                 next_s, ready_s;

   logic                 v1_r, v2_r;
   logic [WIDTH:0]       diff_s, d1_r;
   logic [2*WIDTH:0]     ext_s, sq_s, sq2_r;
   logic [ACC_W:0]       sum_s;
   logic                 acc_sat_s, cnt_sat_s;

   logic [ACC_W-1:0]     acc_r;
   logic [CNT_W-1:0]     cnt_r;
   logic                 ovf_r;

   logic [ACC_W-1:0]     result_s;
   logic [CNT_W-1:0]     result_cnt_s;
   logic                 result_ovf_s;

   logic                 next_r, ready_r, ovf_out_r;
   logic [ACC_W-1:0]     y_r;
   logic [CNT_W-1:0]     count_r;

   assign xfer_s = valid && next_r;
   // The last pair needs two edges to reach acc; the third DRAIN edge reads it.
   assign load_s = (state_r == ST_DRAIN) && (drain_cnt_r == 2'd2);

   // S1 difference at WIDTH+1 bits, S2 square. |d| < 2^WIDTH, so the low
   // 2*WIDTH+1 bits of the sign-extended product are the exact square.
   assign diff_s    = {A[WIDTH-1], A} - {B[WIDTH-1], B};
   assign ext_s     = {{WIDTH{d1_r[WIDTH]}}, d1_r};
   assign sq_s      = ext_s * ext_s;
   assign sum_s     = {1'b0, acc_r} + {{(ACC_W-2*WIDTH){1'b0}}, sq2_r};
   assign acc_sat_s = v2_r && sum_s[ACC_W];
   assign cnt_sat_s = xfer_s && (cnt_r == CNT_MAX);

`ifdef SSE_MEAN_EN
   localparam int DIVC_W = $clog2(ACC_W);
   localparam logic [DIVC_W-1:0] DIV_LAST = DIVC_W'(ACC_W - 1);

   logic [ACC_W-1:0]  rem_r, quo_r, dvs_r;
   logic [DIVC_W-1:0] div_cnt_r;
   logic [CNT_W-1:0]  hold_cnt_r;
   logic              hold_ovf_r;
   logic [ACC_W:0]    rem_sh_s, sub_s;
   logic [ACC_W-1:0]  rem_nx_s, quo_nx_s;
   logic              ge_s;

   // Restoring step; rem < divisor keeps sub_s within ACC_W+1 bits, so its
   // top bit is the borrow.
   assign rem_sh_s = {rem_r, quo_r[ACC_W-1]};
   assign sub_s    = rem_sh_s - {1'b0, dvs_r};
   assign ge_s     = ~sub_s[ACC_W];
   assign rem_nx_s = ge_s ? sub_s[ACC_W-1:0] : rem_sh_s[ACC_W-1:0];
   assign quo_nx_s = {quo_r[ACC_W-2:0], ge_s};

   assign finish_s     = (state_r == ST_DIV) && (div_cnt_r == DIV_LAST);
   assign result_s     = quo_nx_s;
   assign result_cnt_s = hold_cnt_r;
   assign result_ovf_s = hold_ovf_r;

   // Divider registers: loaded with the final sum and count at DRAIN exit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem_r      <= {ACC_W{1'b0}};
         quo_r      <= {ACC_W{1'b0}};
         dvs_r      <= {ACC_W{1'b0}};
         div_cnt_r  <= {DIVC_W{1'b0}};
         hold_cnt_r <= {CNT_W{1'b0}};
         hold_ovf_r <= 1'b0;
      end else if (load_s) begin
         rem_r      <= {ACC_W{1'b0}};
         quo_r      <= acc_r;
         dvs_r      <= {{(ACC_W-CNT_W){1'b0}}, cnt_r};
         div_cnt_r  <= {DIVC_W{1'b0}};
         hold_cnt_r <= cnt_r;
         hold_ovf_r <= ovf_r;
      end else if (state_r == ST_DIV) begin
         rem_r      <= rem_nx_s;
         quo_r      <= quo_nx_s;
         div_cnt_r  <= div_cnt_r + {{(DIVC_W-1){1'b0}}, 1'b1};
      end else begin
         div_cnt_r  <= {DIVC_W{1'b0}};
      end
   end
`else
   assign finish_s     = load_s;
   assign result_s     = acc_r;
   assign result_cnt_s = cnt_r;
   assign result_ovf_s = ovf_r;
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_r <= ST_ACCUM;
      else      state_r <= state_nxt_s;
   end

   // FSM next-state logic; DONE accepts pairs exactly like ACCUM.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_ACCUM, ST_DONE: begin
            if (xfer_s && stop) state_nxt_s = ST_DRAIN;
            else                state_nxt_s = ST_ACCUM;
         end
         ST_DRAIN: begin
`ifdef SSE_MEAN_EN
            if (load_s) state_nxt_s = ST_DIV;
`else
            if (load_s) state_nxt_s = ST_DONE;
`endif
            else        state_nxt_s = ST_DRAIN;
         end
`ifdef SSE_MEAN_EN
         ST_DIV: begin
            if (finish_s) state_nxt_s = ST_DONE;
            else          state_nxt_s = ST_DIV;
         end
`endif
         default: state_nxt_s = ST_ACCUM;
      endcase
   end

   // FSM outputs, decoded from the next state so they can be registered.
   always_comb begin
      next_s  = 1'b0;
      ready_s = 1'b0;
      case (state_nxt_s)
         ST_ACCUM: next_s = 1'b1;
         ST_DONE: begin
            next_s  = 1'b1;
            ready_s = 1'b1;
         end
         default: begin
            next_s  = 1'b0;
            ready_s = 1'b0;
         end
      endcase
   end

   // DRAIN cycle counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                      drain_cnt_r <= 2'd0;
      else if (state_r == ST_DRAIN)  drain_cnt_r <= drain_cnt_r + 2'd1;
      else                           drain_cnt_r <= 2'd0;
   end

   // Pipeline stages S1 (difference) and S2 (square).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1_r  <= 1'b0;
         d1_r  <= {(WIDTH+1){1'b0}};
         v2_r  <= 1'b0;
         sq2_r <= {(2*WIDTH+1){1'b0}};
      end else begin
         v1_r  <= xfer_s;
         if (xfer_s) d1_r <= diff_s;
         else        d1_r <= d1_r;
         v2_r  <= v1_r;
         sq2_r <= sq_s;
      end
   end

   // S3 accumulator, saturating pair counter and sticky overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_r <= {ACC_W{1'b0}};
         cnt_r <= {CNT_W{1'b0}};
         ovf_r <= 1'b0;
      end else if (load_s) begin
         acc_r <= {ACC_W{1'b0}};
         cnt_r <= {CNT_W{1'b0}};
         ovf_r <= 1'b0;
      end else begin
         if (acc_sat_s)  acc_r <= ACC_MAX;
         else if (v2_r)  acc_r <= sum_s[ACC_W-1:0];
         else            acc_r <= acc_r;
         if (xfer_s && !cnt_sat_s) cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         else                      cnt_r <= cnt_r;
         ovf_r <= ovf_r | acc_sat_s | cnt_sat_s;
      end
   end

   // Registered outputs; results load on the edge entering DONE and hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         next_r    <= 1'b0;
         ready_r   <= 1'b0;
         y_r       <= {ACC_W{1'b0}};
         count_r   <= {CNT_W{1'b0}};
         ovf_out_r <= 1'b0;
      end else begin
         next_r  <= next_s;
         ready_r <= ready_s;
         if (finish_s) begin
            y_r       <= result_s;
            count_r   <= result_cnt_s;
            ovf_out_r <= result_ovf_s;
         end else begin
            y_r       <= y_r;
            count_r   <= count_r;
            ovf_out_r <= ovf_out_r;
         end
      end
   end

   assign next     = next_r;
   assign ready    = ready_r;
   assign Y        = y_r;
   assign count    = count_r;
   assign overflow = ovf_out_r;

endmodule
